cpu_core: RTL
=============

// Module: cpu_core
// PURPOSE
//  Parametrised successor of the 16-bit accumulator-less CPU. Executes one 16-bit instruction per accepted handshake
//  over a REGN x N register file. Adds valid/ready instruction fetch, a back-pressured output port, ZF/CF flags,
//  logic/shift ops, HLT and illegal-opcode detection. Sits between the instruction memory (mem) and the output sink.
// PARAMETERS
//  N     16  datapath/register width, 8..32
//  REGN  16  register count, 2..16; reg field is 4 bits, index >= REGN is illegal
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  inst_valid  in   1   instruction present on inst
//  inst_ready  out  1   core accepts inst this cycle
//  inst        in   16  {op[15:12], ra[11:8], rb[7:4], rc[3:0]} | {op, ra, imm8[7:0]}
//  out_valid   out  1   out holds an unconsumed WRO value
//  out_ready   in   1   sink consumes out when out_valid
//  out         out  N   last value written by WRO
//  zf, cf      out  1   zero / carry(borrow) flags of last ALU op
//  halted      out  1   core in HALT
//  illegal     out  1   sticky: illegal opcode or register index seen
// BEHAVIOUR
//  Reset (async, rst_n=0): all regs, out, flags, out_valid, illegal, halted = 0; state RUN.
//  Accept = inst_valid & inst_ready; effects commit on that rising edge; next inst sees updated regs (0-cycle hazard).
//  Opcodes: 0 NOP; 1 LDI ra<=zext(imm8); 2 WRO out<=ra; 3 ADD rc<=ra+rb; 4 SUB rc<=ra-rb; 5 AND; 6 OR; 7 XOR;
//   8 SHL rc<=ra<<rb[3:0]; 9 SHR rc<=ra>>rb[3:0] (logical); 10 MOV rc<=ra; 11 MUL (optional); 15 HLT; others illegal.
//  Arithmetic mod 2^N; ADD cf=carry-out, SUB cf=borrow (ra<rb); zf=(result==0); flags update on ops 3-9 (and 11) only.
//  Self-reference allowed (ADD CX,BX,CX reads old CX).
//  WRO: out<=ra, out_valid<=1; out_valid clears on out_valid&out_ready. WRO issued while out_valid&!out_ready:
//   state OUT_WAIT, inst_ready=0 until out_ready, then out updated (no value lost, no duplicate).
//   Simultaneous consume+new WRO: out_valid stays 1 with new value.
//  States: RUN (inst_ready=1) | OUT_WAIT | MUL_BUSY | HALT. HLT -> HALT; inst_ready=0 until reset.
//  Illegal opcode/reg index: treated as NOP, illegal<=1, no reg/flag change.
//  Reset mid-MUL or mid-OUT_WAIT: operation abandoned, all state cleared.
// CONFIGURATION
//  CPU_MUL_EN defined: op 11 MUL rc<=low N bits of ra*rb, iterative shift-add, N cycles in MUL_BUSY (inst_ready=0);
//   result and zf written on exit, cf=1 if high half nonzero.
//  Not defined: op 11 is illegal (NOP + illegal<=1); MUL_BUSY state and multiplier logic absent.
// STRUCTURE
//  cpu_defs.vh: INST_* opcode defines, AX=0,BX=1,CX=2,DX=3 register defines, state encodings; shared with testbenches/mem.
//  Sub-module cpu_alu: combinational ops 3-10 -> {result, cf, zf}. Reg file, FSM, out port, multiplier in cpu_core.
// TESTING
//  1 LDI AX,42; WRO AX; out_ready=1 -> out=42, out_valid pulses 1 cycle, no x on out after reset.
//  2 LDI AX,20; LDI BX,3; ADD AX,BX,CX; WRO CX -> out=23, cf=0, zf=0.
//  3 LDI AX,3; LDI BX,2; ADD AX,BX,CX; ADD CX,BX,CX x2; WRO CX -> out=9;
//    LDI AX,19; LDI BX,3; SUB AX,BX,CX; WRO CX -> out=16.
//  4 Wrap/flags N=16: LDI AX,0; LDI BX,1; SUB AX,BX,CX -> CX=16'hFFFF, cf=1; ADD CX,BX,CX -> 0, zf=1, cf=1.
//  5 Backpressure: out_ready=0, WRO AX(=5), WRO BX(=7) -> inst_ready=0, out=5 held;
//    out_ready=1 -> out=7 next cycle, then idle.
//  6 Op 12 -> illegal=1, regs unchanged; HLT -> halted=1, inst_ready=0; rst_n pulse low mid-OUT_WAIT -> all zero, RUN.
//    With CPU_MUL_EN: LDI 6, LDI 7, MUL -> 42 after N busy cycles.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared definitions for the cpu_core slice.
//   op_e     - 4-bit opcode encodings (instruction bits [15:12])
//   state_e  - core control states
//   AX..DX   - symbolic register indices 0..3
//   enc_rrr / enc_ri - instruction word builders for benches and memory images
package cpu_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDI = 4'd1,
    OP_WRO = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_MOV = 4'd10,
    OP_MUL = 4'd11,
    OP_HLT = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_OUT_WAIT = 2'd1,
    ST_MUL_BUSY = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  localparam logic [3:0] AX = 4'd0;
  localparam logic [3:0] BX = 4'd1;
  localparam logic [3:0] CX = 4'd2;
  localparam logic [3:0] DX = 4'd3;

  // Three-register form: {op, ra, rb, rc}
  function automatic logic [15:0] enc_rrr(input logic [3:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc};
  endfunction

  // Immediate form: {op, ra, imm8}
  function automatic logic [15:0] enc_ri(input logic [3:0] op, input logic [3:0] ra,
                                         input logic [7:0] imm);
    return {op, ra, imm};
  endfunction

endpackage

// File: rtl/cpu_core_if.sv
// cpu_core_if: instruction fetch handshake plus back-pressured output port.
//   inst_valid/inst_ready/inst  - instruction channel (source -> core)
//   out_valid/out_ready/out     - WRO result channel (core -> sink)
// Modports: master = the core, slave = the environment (memory + sink).
interface cpu_core_if #(
  parameter int N = 16
);
  logic          inst_valid;
  logic          inst_ready;
  logic [15:0]   inst;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out;

  modport master (
    input  inst_valid, inst, out_ready,
    output inst_ready, out_valid, out
  );

  modport slave (
    output inst_valid, inst, out_ready,
    input  inst_ready, out_valid, out
  );
endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational datapath for opcodes ADD..MOV.
//   op      in  4  opcode
//   a, b    in  N  operands (ra, rb)
//   result  out N  operation result mod 2^N
//   cf      out 1  carry-out (ADD) / borrow (SUB), 0 otherwise
//   zf      out 1  result == 0
module cpu_alu
  import cpu_core_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         cf,
  output logic         zf
);

  // Operation select; the extra top bit of the N+1 wide sum/difference is carry/borrow
  always_comb begin
    result = '0;
    cf     = 1'b0;
    case (op)
      OP_ADD:  {cf, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {cf, result} = {1'b0, a} - {1'b0, b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[3:0];
      OP_SHR:  result = a >> b[3:0];
      OP_MOV:  result = a;
      default: result = '0;
    endcase
    zf = (result == '0);
  end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: one 16-bit instruction per accepted handshake over a REGN x N
// register file, with ZF/CF flags, back-pressured output port, HLT and
// sticky illegal-opcode/register detection.
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   bus         - cpu_core_if.master: inst_valid/inst_ready/inst, out_valid/out_ready/out
//   zf, cf      - flags of the last flag-updating op
//   halted      - core is in HALT
//   illegal     - sticky illegal opcode / register index indicator
// Build option: CPU_MUL_EN enables opcode 11 (MUL, iterative shift-add,
// N cycles); without it opcode 11 is illegal.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int N    = 16,
  parameter int REGN = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  cpu_core_if.master bus,
  output logic      zf,
  output logic      cf,
  output logic      halted,
  output logic      illegal
);

  localparam int IW = $clog2(REGN);

  state_e       state_r, state_s;
  logic [N-1:0] regs_r [REGN];
  logic [N-1:0] out_r, pend_r;
  logic         out_valid_r, zf_r, cf_r, illegal_r;

  logic [3:0]   op_s, ra_s, rb_s, rc_s;
  logic [N-1:0] ra_val_s, rb_val_s;
  logic [N-1:0] alu_res_s;
  logic         alu_cf_s, alu_zf_s;
  logic         regs_ok_s;

  logic         wr_en_s, flag_en_s, zf_s, cf_s;
  logic [3:0]   wr_idx_s;
  logic [N-1:0] wr_data_s, out_data_s;
  logic         out_load_s, pend_load_s, set_illegal_s;

`ifdef CPU_MUL_EN
  logic [2*N-1:0] mul_acc_r, mul_mcand_r, mul_acc_next_s;
  logic [N-1:0]   mul_mplier_r;
  logic [5:0]     mul_cnt_r;
  logic [3:0]     mul_rc_r;
  logic           mul_start_s, mul_step_s;
`endif

  // A register index is legal only if it addresses an implemented register
  function automatic logic reg_ok(input logic [3:0] idx);
    return ({1'b0, idx} < 5'(REGN));
  endfunction

  assign op_s = bus.inst[15:12];
  assign ra_s = bus.inst[11:8];
  assign rb_s = bus.inst[7:4];
  assign rc_s = bus.inst[3:0];

  assign ra_val_s = reg_ok(ra_s) ? regs_r[ra_s[IW-1:0]] : '0;
  assign rb_val_s = reg_ok(rb_s) ? regs_r[rb_s[IW-1:0]] : '0;

  cpu_alu #(.N(N)) u_alu (
    .op     (op_s),
    .a      (ra_val_s),
    .b      (rb_val_s),
    .result (alu_res_s),
    .cf     (alu_cf_s),
    .zf     (alu_zf_s)
  );

  // Register-index legality for the fields each opcode actually uses
  always_comb begin
    regs_ok_s = 1'b1;
    case (op_s)
      OP_LDI, OP_WRO: regs_ok_s = reg_ok(ra_s);
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL:
        regs_ok_s = reg_ok(ra_s) && reg_ok(rb_s) && reg_ok(rc_s);
      OP_MOV:  regs_ok_s = reg_ok(ra_s) && reg_ok(rc_s);
      default: regs_ok_s = 1'b1;
    endcase
  end

`ifdef CPU_MUL_EN
  assign mul_acc_next_s = mul_acc_r + (mul_mplier_r[0] ? mul_mcand_r : '0);
`endif

  // Next-state and datapath control
  always_comb begin
    state_s       = state_r;
    wr_en_s       = 1'b0;
    wr_idx_s      = rc_s;
    wr_data_s     = alu_res_s;
    flag_en_s     = 1'b0;
    zf_s          = alu_zf_s;
    cf_s          = alu_cf_s;
    out_load_s    = 1'b0;
    out_data_s    = ra_val_s;
    pend_load_s   = 1'b0;
    set_illegal_s = 1'b0;
`ifdef CPU_MUL_EN
    mul_start_s   = 1'b0;
    mul_step_s    = 1'b0;
`endif
    case (state_r)
      ST_RUN: begin
        if (bus.inst_valid && !regs_ok_s) begin
          set_illegal_s = 1'b1;
        end else if (bus.inst_valid) begin
          case (op_s)
            OP_NOP: state_s = ST_RUN;
            OP_LDI: begin
              wr_en_s   = 1'b1;
              wr_idx_s  = ra_s;
              wr_data_s = N'(bus.inst[7:0]);
            end
            OP_WRO: begin
              // Sink still holding an unconsumed value: park this one
              if (bus.out_valid && !bus.out_ready) begin
                pend_load_s = 1'b1;
                state_s     = ST_OUT_WAIT;
              end else begin
                out_load_s  = 1'b1;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
              wr_en_s   = 1'b1;
              flag_en_s = 1'b1;
            end
            OP_MOV: wr_en_s = 1'b1;
`ifdef CPU_MUL_EN
            OP_MUL: begin
              mul_start_s = 1'b1;
              state_s     = ST_MUL_BUSY;
            end
`endif
            OP_HLT:  state_s = ST_HALT;
            default: set_illegal_s = 1'b1;
          endcase
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_OUT_WAIT: begin
        if (bus.out_ready) begin
          out_load_s = 1'b1;
          out_data_s = pend_r;
          state_s    = ST_RUN;
        end else begin
          state_s    = ST_OUT_WAIT;
        end
      end
`ifdef CPU_MUL_EN
      ST_MUL_BUSY: begin
        mul_step_s = 1'b1;
        if (mul_cnt_r == 6'(N - 1)) begin
          wr_en_s   = 1'b1;
          wr_idx_s  = mul_rc_r;
          wr_data_s = mul_acc_next_s[N-1:0];
          flag_en_s = 1'b1;
          zf_s      = (mul_acc_next_s[N-1:0] == '0);
          cf_s      = |mul_acc_next_s[2*N-1:N];
          state_s   = ST_RUN;
        end else begin
          state_s   = ST_MUL_BUSY;
        end
      end
`endif
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_RUN;
    else        state_r <= state_s;
  end

  // Register file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGN; i++) regs_r[i] <= '0;
    end else if (wr_en_s) begin
      regs_r[wr_idx_s[IW-1:0]] <= wr_data_s;
    end
  end

  // Output port: a new load wins over a simultaneous consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
      pend_r      <= '0;
    end else begin
      if (out_load_s) begin
        out_r       <= out_data_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (pend_load_s) pend_r <= ra_val_s;
    end
  end

  // Flags and sticky illegal indicator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_r      <= 1'b0;
      cf_r      <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      if (flag_en_s) begin
        zf_r <= zf_s;
        cf_r <= cf_s;
      end
      if (set_illegal_s) illegal_r <= 1'b1;
    end
  end

`ifdef CPU_MUL_EN
  // Shift-add multiplier: one multiplier bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_acc_r    <= '0;
      mul_mcand_r  <= '0;
      mul_mplier_r <= '0;
      mul_cnt_r    <= 6'd0;
      mul_rc_r     <= 4'd0;
    end else if (mul_start_s) begin
      mul_acc_r    <= '0;
      mul_mcand_r  <= (2*N)'(ra_val_s);
      mul_mplier_r <= rb_val_s;
      mul_cnt_r    <= 6'd0;
      mul_rc_r     <= rc_s;
    end else if (mul_step_s) begin
      mul_acc_r    <= mul_acc_next_s;
      mul_mcand_r  <= mul_mcand_r << 1;
      mul_mplier_r <= mul_mplier_r >> 1;
      mul_cnt_r    <= mul_cnt_r + 6'd1;
    end
  end
`endif

  assign bus.inst_ready = (state_r == ST_RUN);
  assign bus.out        = out_r;
  assign bus.out_valid  = out_valid_r;
  assign zf             = zf_r;
  assign cf             = cf_r;
  assign halted         = (state_r == ST_HALT);
  assign illegal        = illegal_r;

endmodule
